// File: rtl/dma_pcie_mi_ram_par_wrap.sv
// dma_pcie_mi_ram_par_wrap: parametrised lane-write RAM with byte parity, injection, collision policy and error counters
module dma_pcie_mi_ram_par_wrap #(
  parameter int DATA_W   = 512,
  parameter int ADDR_W   = 8,
  parameter int WE_W     = 2,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 0,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   wadr,
  input  logic [WE_W-1:0]     wen,
  input  logic [DATA_W-1:0]   wdat,
  input  logic [DATA_W/8-1:0] wpar,
  input  logic                ren,
  input  logic [ADDR_W-1:0]   radr,
  output logic                rvld,
  output logic [DATA_W-1:0]   rdat,
  output logic [DATA_W/8-1:0] rpar,
  output logic                rsbe,
  output logic                rdbe,
  output logic                wr_par_err,
  input  logic                inj_sbe,
  input  logic                inj_dbe,
  input  logic                err_clr,
  output logic [CNT_W-1:0]    sbe_cnt,
  output logic [CNT_W-1:0]    dbe_cnt
);
  localparam int NB = DATA_W / 8;
  localparam int LW = DATA_W / WE_W;
  localparam int LB = LW / 8;
  logic [DATA_W-1:0] mem_d [2**ADDR_W];
  logic [NB-1:0]     mem_p [2**ADDR_W];
  logic [NB-1:0]     inj_m, wpar_i, wmm, bmask, rmm, rp_nd, p1;
  logic [DATA_W-1:0] rd_nd, d1;
  logic              v1, sbe1, dbe1;
  // lowest enabled lane wins the injection: loop runs high to low so the last hit sticks
  always_comb begin
    inj_m = '0;
    bmask = '0;
    wmm   = '0;
    for (int k = WE_W - 1; k >= 0; k--)
      if (wen[k]) inj_m = (inj_dbe ? NB'(3) : NB'(inj_sbe)) << (k * LB);
    for (int i = 0; i < NB; i++) begin
      bmask[i] = wen[i/LB];
      wmm[i]   = ^wdat[8*i +: 8] ^ wpar[i];
    end
    wpar_i = wpar ^ inj_m;
    rd_nd  = mem_d[radr];
    rp_nd  = mem_p[radr];
    for (int k = 0; k < WE_W; k++)
      if (WR_FIRST != 0 && wen[k] && wadr == radr) begin
        rd_nd[k*LW +: LW] = wdat[k*LW +: LW];
        rp_nd[k*LB +: LB] = wpar_i[k*LB +: LB];
      end
  end
  always_ff @(posedge clk)
    for (int k = 0; k < WE_W; k++)
      if (wen[k]) begin
        mem_d[wadr][k*LW +: LW] <= wdat[k*LW +: LW];
        mem_p[wadr][k*LB +: LB] <= wpar_i[k*LB +: LB];
      end
  always_ff @(posedge clk)
    if (rst) begin
      v1         <= 1'b0;
      d1         <= '0;
      p1         <= '0;
      wr_par_err <= 1'b0;
    end else begin
      v1         <= ren;
      wr_par_err <= |(wmm & bmask);
      if (ren) begin
        d1 <= rd_nd;
        p1 <= rp_nd;
      end
    end
  always_comb
    for (int i = 0; i < NB; i++) rmm[i] = ^d1[8*i +: 8] ^ p1[i];
  // clearing the lowest set bit leaves zero exactly when at most one byte mismatched
  assign sbe1 = v1 && rmm != '0 && (rmm & (rmm - NB'(1))) == '0;
  assign dbe1 = v1 && (rmm & (rmm - NB'(1))) != '0;
  if (RD_LAT == 2) begin : g_l2
    always_ff @(posedge clk)
      if (rst) begin
        rvld <= 1'b0;
        rdat <= '0;
        rpar <= '0;
        rsbe <= 1'b0;
        rdbe <= 1'b0;
      end else begin
        rvld <= v1;
        rsbe <= sbe1;
        rdbe <= dbe1;
        if (v1) begin
          rdat <= d1;
          rpar <= p1;
        end
      end
  end else begin : g_l1
    assign rvld = v1;
    assign rdat = d1;
    assign rpar = p1;
    assign rsbe = sbe1;
    assign rdbe = dbe1;
  end
  always_ff @(posedge clk)
    if (rst || err_clr) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else begin
      if (rvld && rsbe && sbe_cnt != '1) sbe_cnt <= sbe_cnt + CNT_W'(1);
      if (rvld && rdbe && dbe_cnt != '1) dbe_cnt <= dbe_cnt + CNT_W'(1);
    end
endmodule

// File: doc/dma_pcie_mi_ram_par_wrap.md
Name: dma_pcie_mi_ram_par_wrap

Overview:
- Parametrised single-port-write/single-port-read RAM wrapper for the DMA PCIe memory-interface (MI) RAMs.
- Successor to the fixed 64Bx256, 2-lane-write-enable RAM slave. Adds parametrised width, depth, write-lane count and read latency.
- Adds a write-first/read-first collision policy, write-side parity check, parity-error injection and saturating error counters.
- Instantiated behind DMA descriptor/context RAM interfaces; the caller sees a registered read pipeline with per-read single/multi-byte error flags.

Parameters:
- DATA_W, 512, data width in bits; multiple of 8*WE_W.
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- WE_W, 2, write-enable lanes; each lane covers DATA_W/WE_W bits.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_FIRST, 0, collision policy: 0 = read-first (old data), 1 = write-first (new data).
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wadr  in  ADDR_W  write address
- wen  in  WE_W  per-lane write enable
- wdat  in  DATA_W  write data
- wpar  in  DATA_W/8  even parity, one bit per byte
- ren  in  1  read enable
- radr  in  ADDR_W  read address
- rvld  out  1  rdat/rpar/flags valid
- rdat  out  DATA_W  read data
- rpar  out  DATA_W/8  stored parity of the read word
- rsbe  out  1  exactly one byte has a parity mismatch
- rdbe  out  1  two or more bytes have a parity mismatch
- wr_par_err  out  1  pulse: wpar disagrees with wdat on an enabled lane
- inj_sbe  in  1  with write: corrupt one parity bit
- inj_dbe  in  1  with write: corrupt two parity bits
- err_clr  in  1  clear both counters
- sbe_cnt  out  CNT_W  saturating count of rsbe events
- dbe_cnt  out  CNT_W  saturating count of rdbe events

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: rvld, rsbe, rdbe, wr_par_err = 0; rdat, rpar = 0; sbe_cnt, dbe_cnt = 0.
- Memory array is not reset. Its contents after reset are undefined; reads of unwritten locations are unspecified.
- Write: on a clk edge with wen[k]=1, lane k of mem[wadr] takes wdat and wpar for that lane. wen=0 means no write.
- Write parity check: a byte is checked only when its lane is enabled; a byte mismatches when ^byte != its wpar bit. Any mismatch drives wr_par_err=1 for one cycle, registered one cycle after the write. The data is still stored with the supplied wpar.
- Injection applies to the lowest enabled lane and is ignored when wen=0.
  - inj_sbe: stored parity bit of byte 0 of that lane is inverted.
  - inj_dbe: bytes 0 and 1 of that lane are inverted; inj_dbe wins if both injection inputs are set.
- Read: ren at edge T drives rvld=1 with rdat/rpar/rsbe/rdbe valid after edge T+RD_LAT. Fully pipelined: one read per cycle.
- When rvld=0, rdat/rpar hold their last values and rsbe/rdbe are 0.
- RD_LAT=2 adds an output register after the parity check. The flags are computed on the stage-1 data.
- Read check: mismatch count N = number of bytes where ^rdat_byte != rpar_bit. N=1 gives rsbe=1; N>=2 gives rdbe=1 and rsbe=0; N=0 gives both 0.
- Collision (ren and any wen, radr==wadr, same edge):
  - WR_FIRST=0: read returns pre-write content.
  - WR_FIRST=1: enabled lanes return new wdat/wpar (after injection); disabled lanes return old content.
- Counters: sbe_cnt increments when rvld and rsbe are both 1; dbe_cnt increments when rvld and rdbe are both 1. Both saturate at 2**CNT_W-1.
- err_clr zeroes both counters on the next edge; err_clr takes priority over a same-cycle increment.
- Reset mid-operation: all in-flight reads are dropped. rvld=0 on the edge after rst and stays 0 until a new ren following rst deassertion. A write coinciding with rst is still performed.

Test Plan:
- Reset, then write 0xA5 to every byte with correct parity (0 per byte) at address 0x10, wen=2'b11; ren radr=0x10 -> rvld exactly RD_LAT cycles later, rdat=all 0xA5, rsbe=0, rdbe=0, wr_par_err never asserted.
- Partial write: write addr 3 all 0x11, then wen=2'b10 with data 0x22 -> read gives lane0=0x11 bytes, lane1=0x22 bytes, correct parity.
- Injection: write addr 5 with inj_sbe=1, read -> rsbe=1, rdbe=0, sbe_cnt=1. Write addr 6 with inj_dbe=1, read -> rdbe=1, rsbe=0, dbe_cnt=1. Assert err_clr on the same cycle as a further rsbe -> sbe_cnt=0.
- Write with wpar bit 7 flipped -> wr_par_err=1 for one cycle; subsequent read of that word -> rsbe=1.
- Collision at addr 0x20 (old 0x00, new 0xFF, wen=2'b01): WR_FIRST=0 -> all 0x00; WR_FIRST=1 -> lane0 0xFF, lane1 0x00.
- Back-to-back reads on 4 addresses, rst asserted on the 2nd rvld cycle -> no rvld after rst until a new ren. Also force 2**CNT_W+3 rsbe events -> sbe_cnt holds 0xFFFF.
